fpga_io_regs_param: RTL
=======================

# fpga_io_regs_param

Parametrised APB FPGA I/O register block for the V2M-MPS2 FPGA subsystem. It is the next generation of the fixed 2-LED/2-button I/O register block, and adds:

- configurable LED, button and misc widths;
- per-button debounce on the 100 Hz tick;
- button-press and cycle-counter-compare interrupts, collected on one `irq` output.

It sits on the APB peripheral bus alongside the other FPGA system registers.

## Interface
Parameters:
- `LED_W`, 8: LED output width, 1..32.
- `BTN_W`, 4: button input width, 1..31.
- `MISC_W`, 10: `fpga_misc` width, 1..32.
- `DEBOUNCE_TICKS`, 2: consecutive 100 Hz ticks a button must differ before it is accepted; 0 = bypass; maximum 15.
- `MISC_RESET`, all ones: reset value of `fpga_misc`.

Ports:
- `PCLK` in 1: single clock for all logic.
- `PRESETn` in 1: reset; asynchronous, active-low.
- `PSEL`, `PENABLE`, `PWRITE` in 1: APB control.
- `PADDR` in [11:2]: word address.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: tied 1.
- `PSLVERR` out 1: tied 0.
- `clk_100hz` in 1: asynchronous 100 Hz reference.
- `buttons` in BTN_W: asynchronous, active-high.
- `leds` out LED_W: LED register.
- `fpga_misc` out MISC_W: misc output register.
- `irq` out 1: level interrupt, `|(IRQ_STATUS & IRQ_EN)`.

## Operation
Register map (byte offset). Unused upper bits read 0. Unmapped offsets read 0 and ignore writes.
- 0x000 LED, RW.
- 0x004 LED_TOGGLE, WO: `leds ^= PWDATA`.
- 0x008 BUTTON, RO: debounced state.
- 0x00C BTN_RAW, RO: synchroniser output.
- 0x010 CNT_1HZ, RW.
- 0x014 CNT_100HZ, RW.
- 0x018 CNT_CYCLE, RW.
- 0x01C PRESCALE, RW: a write also loads PS_CNTR.
- 0x020 PS_CNTR, RW.
- 0x024 CYCLE_CMP, RW.
- 0x028 IRQ_STATUS, W1C:
  - bits [BTN_W-1:0]: button press;
  - bit BTN_W: cycle-counter match.
- 0x02C IRQ_EN, RW, same bit layout as IRQ_STATUS.
- 0x04C MISC, RW.
- 0xFD0–0xFFC ID registers:
  - PID4..7 = 04, 00, 00, 00;
  - PID0..3 = 51, B8, 0B, 00;
  - CID0..3 = 0D, F0, 05, B1.

Register behaviour:
- **Writes:** take effect when `PSEL & PENABLE & PWRITE`.
- **Reads:** `PRDATA` is combinational, non-zero only when `PSEL & ~PWRITE`.
- **Reset values:**
  - all registers and counters: 0;
  - `fpga_misc`: `MISC_RESET`;
  - `irq`: 0.
- **Buttons:** two-flop synchroniser produces BTN_RAW. A debounce counter per button (4 bits) advances on each tick while BTN_RAW differs from BUTTON, and clears to 0 when they match.
  - When the count reaches DEBOUNCE_TICKS, BUTTON takes BTN_RAW and the count clears.
  - DEBOUNCE_TICKS = 0: BUTTON equals BTN_RAW delayed one cycle.
  - A 0→1 transition of BUTTON[n] sets IRQ_STATUS[n].
- **100 Hz tick:** three-flop synchroniser on `clk_100hz`, then a rising-edge detect gives a one-cycle tick.
  - CNT_100HZ increments on each tick.
  - A 0..99 divider advances on each tick; CNT_1HZ increments on the tick where the divider equals 99.
  - Writing CNT_1HZ also clears the divider.
- **Cycle counter:**
  - PS_CNTR decrements every cycle; at 0 it reloads from PRESCALE.
  - CNT_CYCLE increments in each cycle where PS_CNTR = 0.
  - When an increment makes the next CNT_CYCLE equal CYCLE_CMP, IRQ_STATUS[BTN_W] is set.
  - A software write equal to CYCLE_CMP does not set it.
- **Arithmetic:** all counters are 32-bit and wrap modulo 2^32, e.g. FFFF_FFFF → 0. A match at 0 after wrap is valid.
- **Precedence:**
  - an APB write to a counter beats a same-cycle increment;
  - a hardware status set beats a same-cycle W1C of the same bit.

## Timing
- APB is zero-wait: setup plus access, 2 PCLK per transfer. A written value is visible on the next cycle.
- `irq` is combinational from registered STATUS/EN. It rises one cycle after the status bit is set, and falls one cycle after a W1C or IRQ_EN clear.
- Tick latency: the tick pulses 2–3 PCLK after the `clk_100hz` rising edge, and the counters update on the following edge.
- Button latency:
  - 2 PCLK to BTN_RAW;
  - a further DEBOUNCE_TICKS ticks to BUTTON;
  - status sets on the same edge BUTTON rises.
- A bounce shorter than DEBOUNCE_TICKS consecutive ticks leaves BUTTON unchanged.
- PRESCALE = 0: CNT_CYCLE increments every PCLK. PRESCALE = N: it increments every N+1 PCLK.
- Asserting `PRESETn` mid-operation clears all state immediately, including synchronisers and debounce counters. The first tick after release needs a fresh `clk_100hz` rising edge.

## Test plan
- **Reset and ID:** after reset, read every register → 0, MISC = `MISC_RESET`, `irq` = 0. Read 0xFE0 → 0x51 and 0xFFC → 0xB1.
- **LED:** write LED = 0xA5, then LED_TOGGLE = 0x0F → `leds` = 0xAA. A write of 0xFFFF_FF00 with LED_W = 8 → `leds` = 0x00.
- **Debounce** (DEBOUNCE_TICKS = 2):
  - button[1] high for 1 tick → BUTTON stays 0, no status;
  - high for 3 ticks → BUTTON[1] = 1 after the 2nd tick, IRQ_STATUS = 0x2;
  - with IRQ_EN = 0x2, `irq` = 1 next cycle; W1C 0x2 → `irq` = 0.
- **Prescale and match:** PRESCALE = 3, CNT_CYCLE = 0, CYCLE_CMP = 5, IRQ_EN bit 4 set → CNT_CYCLE steps every 4 PCLK. Status bit 4 sets on the edge CNT_CYCLE becomes 5, and `irq` follows.
- **Wrap and precedence:**
  - CNT_CYCLE = 0xFFFF_FFFF, PRESCALE = 0, CYCLE_CMP = 0 → next value 0 and match set;
  - W1C in the same cycle as a set → the bit stays 1.
- **1 Hz:** write CNT_1HZ = 7, then apply 100 `clk_100hz` edges → CNT_1HZ = 8 and CNT_100HZ = 100. Assert `PRESETn` mid-sequence → all counters = 0.

Source files
------------

// File: rtl/fpga_io_regs_param.sv
// APB FPGA I/O register block: LEDs, debounced buttons, 100 Hz / 1 Hz / cycle
// counters with compare, button/compare interrupts and a misc output register.
module fpga_io_regs_param #(
  parameter int unsigned       LED_W          = 8,
  parameter int unsigned       BTN_W          = 4,
  parameter int unsigned       MISC_W         = 10,
  parameter int unsigned       DEBOUNCE_TICKS = 2,
  parameter logic [MISC_W-1:0] MISC_RESET     = {MISC_W{1'b1}}
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:2]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              clk_100hz,
  input  logic [BTN_W-1:0]  buttons,
  output logic [LED_W-1:0]  leds,
  output logic [MISC_W-1:0] fpga_misc,
  output logic              irq
);

  localparam int unsigned IRQ_W   = BTN_W + 1;
  localparam logic [3:0]  DEB_MAX = 4'(DEBOUNCE_TICKS);

  localparam logic [9:0] A_LED  = 10'h000, A_TOGL = 10'h001, A_BTN  = 10'h002,
                         A_RAW  = 10'h003, A_C1   = 10'h004, A_C100 = 10'h005,
                         A_CCYC = 10'h006, A_PRE  = 10'h007, A_PSC  = 10'h008,
                         A_CMP  = 10'h009, A_IST  = 10'h00A, A_IEN  = 10'h00B,
                         A_MISC = 10'h013;

  logic [LED_W-1:0]      leds_q, leds_d;
  logic [MISC_W-1:0]     misc_q, misc_d;
  logic [BTN_W-1:0]      btn_meta_q, btn_raw_q, button_q, button_d;
  logic [BTN_W-1:0][3:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]            hz_sync_q, hz_sync_d;
  logic                  hz_valid_q, hz_armed_q, hz_armed_d;
  logic [6:0]            div_q, div_d;
  logic [31:0]           cnt_1hz_q, cnt_1hz_d, cnt_100hz_q, cnt_100hz_d;
  logic [31:0]           cnt_cycle_q, cnt_cycle_d, prescale_q, prescale_d;
  logic [31:0]           ps_cntr_q, ps_cntr_d, cycle_cmp_q, cycle_cmp_d;
  logic [IRQ_W-1:0]      irq_status_q, irq_status_d, irq_en_q, irq_en_d;

  logic        wr_c, tick_c, cyc_inc_c, match_c;
  logic [31:0] cyc_next_c, prdata_c;
  logic [BTN_W-1:0] btn_rise_c;

  // Next-state logic for every register
  always_comb begin
    leds_d       = leds_q;
    misc_d       = misc_q;
    button_d     = button_q;
    deb_cnt_d    = deb_cnt_q;
    hz_sync_d    = {hz_sync_q[1:0], clk_100hz};
    hz_armed_d   = hz_armed_q | (hz_valid_q & ~hz_sync_q[0]);
    div_d        = div_q;
    cnt_1hz_d    = cnt_1hz_q;
    cnt_100hz_d  = cnt_100hz_q;
    cnt_cycle_d  = cnt_cycle_q;
    prescale_d   = prescale_q;
    ps_cntr_d    = ps_cntr_q;
    cycle_cmp_d  = cycle_cmp_q;
    irq_status_d = irq_status_q;
    irq_en_d     = irq_en_q;

    wr_c   = PSEL & PENABLE & PWRITE;
    // Armed only once a genuine low has been sampled after reset
    tick_c = hz_sync_q[1] & ~hz_sync_q[2] & hz_armed_q;

    for (int i = 0; i < int'(BTN_W); i++) begin
      if (DEBOUNCE_TICKS == 0) begin
        button_d[i]  = btn_raw_q[i];
        deb_cnt_d[i] = 4'd0;
      end else if (btn_raw_q[i] == button_q[i]) begin
        deb_cnt_d[i] = 4'd0;
      end else if (tick_c) begin
        if (deb_cnt_q[i] + 4'd1 == DEB_MAX) begin
          button_d[i]  = btn_raw_q[i];
          deb_cnt_d[i] = 4'd0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
        end
      end
    end
    btn_rise_c = button_d & ~button_q;

    if (tick_c) begin
      cnt_100hz_d = cnt_100hz_q + 32'd1;
      if (div_q == 7'd99) begin
        div_d     = 7'd0;
        cnt_1hz_d = cnt_1hz_q + 32'd1;
      end else begin
        div_d = div_q + 7'd1;
      end
    end

    cyc_inc_c  = (ps_cntr_q == 32'd0);
    cyc_next_c = cnt_cycle_q + 32'd1;
    ps_cntr_d  = cyc_inc_c ? prescale_q : ps_cntr_q - 32'd1;
    if (cyc_inc_c) cnt_cycle_d = cyc_next_c;
    match_c    = cyc_inc_c && (cyc_next_c == cycle_cmp_q) && !(wr_c && PADDR == A_CCYC);

    if (wr_c) begin
      case (PADDR)
        A_LED:  leds_d      = PWDATA[LED_W-1:0];
        A_TOGL: leds_d      = leds_q ^ PWDATA[LED_W-1:0];
        A_C1:   begin cnt_1hz_d = PWDATA; div_d = 7'd0; end
        A_C100: cnt_100hz_d = PWDATA;
        A_CCYC: cnt_cycle_d = PWDATA;
        A_PRE:  begin prescale_d = PWDATA; ps_cntr_d = PWDATA; end
        A_PSC:  ps_cntr_d   = PWDATA;
        A_CMP:  cycle_cmp_d = PWDATA;
        A_IST:  irq_status_d = irq_status_q & ~PWDATA[IRQ_W-1:0];
        A_IEN:  irq_en_d    = PWDATA[IRQ_W-1:0];
        A_MISC: misc_d      = PWDATA[MISC_W-1:0];
        default: ;
      endcase
    end
    // Hardware set overrides a same-cycle clear
    irq_status_d = irq_status_d | {match_c, btn_rise_c};
  end

  // Read mux, live only for an APB read
  always_comb begin
    prdata_c = 32'd0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        A_LED:   prdata_c = 32'(leds_q);
        A_BTN:   prdata_c = 32'(button_q);
        A_RAW:   prdata_c = 32'(btn_raw_q);
        A_C1:    prdata_c = cnt_1hz_q;
        A_C100:  prdata_c = cnt_100hz_q;
        A_CCYC:  prdata_c = cnt_cycle_q;
        A_PRE:   prdata_c = prescale_q;
        A_PSC:   prdata_c = ps_cntr_q;
        A_CMP:   prdata_c = cycle_cmp_q;
        A_IST:   prdata_c = 32'(irq_status_q);
        A_IEN:   prdata_c = 32'(irq_en_q);
        A_MISC:  prdata_c = 32'(misc_q);
        10'h3F4: prdata_c = 32'h04;
        10'h3F8: prdata_c = 32'h51;
        10'h3F9: prdata_c = 32'hB8;
        10'h3FA: prdata_c = 32'h0B;
        10'h3FC: prdata_c = 32'h0D;
        10'h3FD: prdata_c = 32'hF0;
        10'h3FE: prdata_c = 32'h05;
        10'h3FF: prdata_c = 32'hB1;
        default: prdata_c = 32'd0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      leds_q       <= '0;
      misc_q       <= MISC_RESET;
      btn_meta_q   <= '0;
      btn_raw_q    <= '0;
      button_q     <= '0;
      deb_cnt_q    <= '0;
      hz_sync_q    <= '0;
      hz_valid_q   <= 1'b0;
      hz_armed_q   <= 1'b0;
      div_q        <= '0;
      cnt_1hz_q    <= '0;
      cnt_100hz_q  <= '0;
      cnt_cycle_q  <= '0;
      prescale_q   <= '0;
      ps_cntr_q    <= '0;
      cycle_cmp_q  <= '0;
      irq_status_q <= '0;
      irq_en_q     <= '0;
    end else begin
      leds_q       <= leds_d;
      misc_q       <= misc_d;
      btn_meta_q   <= buttons;
      btn_raw_q    <= btn_meta_q;
      button_q     <= button_d;
      deb_cnt_q    <= deb_cnt_d;
      hz_sync_q    <= hz_sync_d;
      hz_valid_q   <= 1'b1;
      hz_armed_q   <= hz_armed_d;
      div_q        <= div_d;
      cnt_1hz_q    <= cnt_1hz_d;
      cnt_100hz_q  <= cnt_100hz_d;
      cnt_cycle_q  <= cnt_cycle_d;
      prescale_q   <= prescale_d;
      ps_cntr_q    <= ps_cntr_d;
      cycle_cmp_q  <= cycle_cmp_d;
      irq_status_q <= irq_status_d;
      irq_en_q     <= irq_en_d;
    end
  end

  assign PRDATA    = prdata_c;
  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign leds      = leds_q;
  assign fpga_misc = misc_q;
  assign irq       = |(irq_status_q & irq_en_q);

endmodule
